dbg_display_ctrl: RTL and testbench

Parametrised debug front-end for the FPGA top level. It replaces the derived slow-clock scheme with a single-domain clock-enable generator for the CPU (`cpu_ce`), with two modes:
- free-run at a programmable rate;
- single-step from a debounced push-button.

It snapshots one of `NUM_CH` CPU debug words after every CPU step and shows the snapshot on `NUM_DIGITS` time-multiplexed seven-segment digits.

---
 rtl/dbg_display_ctrl.sv | 156 +++++++++++++++
 tb/tb_dbg_display_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dbg_display_ctrl.sv
// Debug front-end: CPU clock-enable (free-run or debounced single-step),
// debug-word snapshot and multiplexed seven-segment hex display.
module dbg_display_ctrl #(
    parameter int DIVIDE_BY  = 5000000,
    parameter int DEBOUNCE   = 1000000,
    parameter int SCAN_DIV   = 100000,
    parameter int DATA_W     = 32,
    parameter int NUM_CH     = 4,
    parameter int NUM_DIGITS = 8,
    localparam int SEL_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mode_run,
    input  logic                     step_btn,
    input  logic [SEL_W-1:0]         ch_sel,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic                     cpu_ce,
    output logic [6:0]               seg,
    output logic [NUM_DIGITS-1:0]    an,
    output logic                     dp
);

    localparam int DIV_W = $clog2(DIVIDE_BY);
    localparam int DB_W  = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int SC_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [DIV_W-1:0]      div_q, div_d;
    logic                  sync1_q, sync2_q;
    logic [DB_W-1:0]       db_cnt_q, db_cnt_d;
    logic                  db_q, db_d, db_prev_q;
    logic                  ce_q, ce_d, ce_dly_q;
    logic [SEL_W-1:0]      sel_q;
    logic [DATA_W-1:0]     snap_q, snap_d, sel_data;
    logic [SC_W-1:0]       scan_q, scan_d;
    logic [DIG_W-1:0]      digit_q, digit_d;
    logic [3:0]            nib;
    logic [6:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  dp_q, dp_d;
    logic                  run_hit, step_hit;

    function automatic logic [6:0] hex_font(input logic [3:0] v);
        unique case (v)
            4'h0: hex_font = 7'h40;
            4'h1: hex_font = 7'h79;
            4'h2: hex_font = 7'h24;
            4'h3: hex_font = 7'h30;
            4'h4: hex_font = 7'h19;
            4'h5: hex_font = 7'h12;
            4'h6: hex_font = 7'h02;
            4'h7: hex_font = 7'h78;
            4'h8: hex_font = 7'h00;
            4'h9: hex_font = 7'h10;
            4'hA: hex_font = 7'h08;
            4'hB: hex_font = 7'h03;
            4'hC: hex_font = 7'h46;
            4'hD: hex_font = 7'h21;
            4'hE: hex_font = 7'h06;
            4'hF: hex_font = 7'h0E;
        endcase
    endfunction

    always_comb begin
        div_d = '0;
        if (mode_run) begin
            div_d = (div_q == DIV_W'(DIVIDE_BY - 1)) ? '0 : div_q + 1'b1;
        end

        db_cnt_d = '0;
        db_d     = db_q;
        if (sync2_q != db_q) begin
            if (db_cnt_q == DB_W'(DEBOUNCE - 1)) begin
                db_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end

        // Guard keeps cpu_ce single-cycle across run/step mode flips.
        run_hit  = mode_run && (div_q == DIV_W'(DIVIDE_BY - 1));
        step_hit = !mode_run && db_q && !db_prev_q;
        ce_d     = (run_hit || step_hit) && !ce_q;

        sel_data = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ch_sel == SEL_W'(k)) begin
                sel_data = ch_data[k*DATA_W +: DATA_W];
            end
        end
        snap_d = snap_q;
        if (ce_dly_q || (ch_sel != sel_q)) begin
            snap_d = sel_data;
        end

        scan_d  = scan_q + 1'b1;
        digit_d = digit_q;
        if (scan_q == SC_W'(SCAN_DIV - 1)) begin
            scan_d  = '0;
            digit_d = (digit_q == DIG_W'(NUM_DIGITS - 1)) ? '0 : digit_q + 1'b1;
        end

        nib = 4'h0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit_q == DIG_W'(i)) begin
                nib = snap_q[4*i +: 4];
            end
        end
        seg_d = hex_font(nib);
        an_d  = ~(NUM_DIGITS'(1) << digit_q);
        dp_d  = !(!mode_run && (digit_q == DIG_W'(NUM_DIGITS - 1)));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q     <= '0;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            db_cnt_q  <= '0;
            db_q      <= 1'b0;
            db_prev_q <= 1'b0;
            ce_q      <= 1'b0;
            ce_dly_q  <= 1'b0;
            sel_q     <= '0;
            snap_q    <= '0;
            scan_q    <= '0;
            digit_q   <= '0;
            seg_q     <= 7'h40;
            an_q      <= ~NUM_DIGITS'(1);
            dp_q      <= 1'b1;
        end else begin
            div_q     <= div_d;
            sync1_q   <= step_btn;
            sync2_q   <= sync1_q;
            db_cnt_q  <= db_cnt_d;
            db_q      <= db_d;
            db_prev_q <= db_q;
            ce_q      <= ce_d;
            ce_dly_q  <= ce_q;
            sel_q     <= ch_sel;
            snap_q    <= snap_d;
            scan_q    <= scan_d;
            digit_q   <= digit_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
            dp_q      <= dp_d;
        end
    end

    assign cpu_ce = ce_q;
    assign seg    = seg_q;
    assign an     = an_q;
    assign dp     = dp_q;

endmodule

// File: tb/tb_dbg_display_ctrl.sv
// Directed bench for dbg_display_ctrl with small timing parameters.
module tb_dbg_display_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mode_run = 1'b0;
    logic        step_btn = 1'b0;
    logic [0:0]  ch_sel = 1'b0;
    logic [31:0] ch_data = '0;
    logic        cpu_ce;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        dp;

    logic        mode2 = 1'b0;
    logic        btn2 = 1'b0;
    logic [1:0]  ch_sel2 = 2'd0;
    logic [47:0] ch_data2 = {16'h3333, 16'h2222, 16'h1111};
    logic        ce2;
    logic [6:0]  seg2;
    logic [3:0]  an2;
    logic        dp2;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [6:0] FONT [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                              7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03,
                              7'h46, 7'h21, 7'h06, 7'h0E};

    always #5 clk = ~clk;

    dbg_display_ctrl #(
        .DIVIDE_BY(4), .DEBOUNCE(3), .SCAN_DIV(2),
        .DATA_W(16), .NUM_CH(2), .NUM_DIGITS(4)
    ) dut (
        .clk(clk), .rst(rst), .mode_run(mode_run), .step_btn(step_btn),
        .ch_sel(ch_sel), .ch_data(ch_data), .cpu_ce(cpu_ce),
        .seg(seg), .an(an), .dp(dp)
    );

    dbg_display_ctrl #(
        .DIVIDE_BY(4), .DEBOUNCE(3), .SCAN_DIV(2),
        .DATA_W(16), .NUM_CH(3), .NUM_DIGITS(4)
    ) dut3 (
        .clk(clk), .rst(rst), .mode_run(mode2), .step_btn(btn2),
        .ch_sel(ch_sel2), .ch_data(ch_data2), .cpu_ce(ce2),
        .seg(seg2), .an(an2), .dp(dp2)
    );

    function automatic int dig_of(input logic [3:0] a);
        case (a)
            4'hE: dig_of = 0;
            4'hD: dig_of = 1;
            4'hB: dig_of = 2;
            4'h7: dig_of = 3;
            default: dig_of = -1;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        total_cnt++;
        if ({cpu_ce, seg, an, dp} !== {1'b0, 7'h40, 4'hE, 1'b1})
            $display("FAIL reset: got ce=%b seg=%h an=%h dp=%b want 0/40/e/1",
                     cpu_ce, seg, an, dp);
        else pass_cnt++;
        rst = 1'b1;
    endtask

    task automatic test_run();
        mode_run = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            total_cnt++;
            if (cpu_ce !== (k % 4 == 0))
                $display("FAIL run_ce k=%0d: got %b want %b", k, cpu_ce, k % 4 == 0);
            else pass_cnt++;
        end
        mode_run = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_step();
        step_btn = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            total_cnt++;
            if (cpu_ce !== (k == 6))
                $display("FAIL step_ce k=%0d: got %b want %b", k, cpu_ce, k == 6);
            else pass_cnt++;
        end
        step_btn = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            total_cnt++;
            if (cpu_ce !== 1'b0)
                $display("FAIL step_release k=%0d: got %b want 0", k, cpu_ce);
            else pass_cnt++;
        end
        step_btn = 1'b1;
        repeat (2) tick();
        step_btn = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            total_cnt++;
            if (cpu_ce !== 1'b0)
                $display("FAIL glitch k=%0d: got %b want 0", k, cpu_ce);
            else pass_cnt++;
        end
    endtask

    task automatic test_display();
        logic [15:0] want;
        logic [3:0]  seen;
        int d;
        ch_data = {16'hBEEF, 16'h1234};
        ch_sel = 1'b1;
        want = 16'hBEEF;
        seen = '0;
        repeat (4) tick();
        for (int k = 0; k < 8; k++) begin
            tick();
            d = dig_of(an);
            total_cnt++;
            if (d < 0) begin
                $display("FAIL scan_an: got %h want one-hot-low", an);
            end else if (seg !== FONT[want[4*d +: 4]] || dp !== (d != 3)) begin
                $display("FAIL scan_seg d=%0d: got seg=%h dp=%b want seg=%h dp=%b",
                         d, seg, dp, FONT[want[4*d +: 4]], d != 3);
            end else begin
                pass_cnt++;
                seen[d] = 1'b1;
            end
        end
        total_cnt++;
        if (seen !== 4'hF) $display("FAIL scan_cover: got %b want 1111", seen);
        else pass_cnt++;
    endtask

    task automatic test_hold_then_step();
        logic [15:0] want;
        int d;
        ch_sel = 1'b0;
        repeat (4) tick();
        ch_data[15:0] = 16'hA5A5;
        repeat (4) tick();
        want = 16'h1234;
        for (int k = 0; k < 8; k++) begin
            tick();
            d = dig_of(an);
            total_cnt++;
            if (d < 0 || seg !== FONT[want[4*d +: 4]])
                $display("FAIL hold an=%h: got seg=%h want digit of %h", an, seg, want);
            else pass_cnt++;
        end
        step_btn = 1'b1;
        repeat (10) tick();
        step_btn = 1'b0;
        repeat (10) tick();
        want = 16'hA5A5;
        for (int k = 0; k < 8; k++) begin
            tick();
            d = dig_of(an);
            total_cnt++;
            if (d < 0 || seg !== FONT[want[4*d +: 4]])
                $display("FAIL stepped an=%h: got seg=%h want digit of %h", an, seg, want);
            else pass_cnt++;
        end
    endtask

    task automatic test_mode_switch();
        mode_run = 1'b1;
        step_btn = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            total_cnt++;
            if (cpu_ce !== (k % 4 == 0))
                $display("FAIL run_press k=%0d: got %b want %b", k, cpu_ce, k % 4 == 0);
            else pass_cnt++;
        end
        mode_run = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            total_cnt++;
            if (cpu_ce !== 1'b0)
                $display("FAIL switch k=%0d: got %b want 0", k, cpu_ce);
            else pass_cnt++;
        end
        step_btn = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_reset_mid_scan();
        repeat (3) tick();
        #2;
        rst = 1'b0;
        #1;
        total_cnt++;
        if ({cpu_ce, seg, an, dp} !== {1'b0, 7'h40, 4'hE, 1'b1})
            $display("FAIL reset_mid: got ce=%b seg=%h an=%h dp=%b want 0/40/e/1",
                     cpu_ce, seg, an, dp);
        else pass_cnt++;
        tick();
        rst = 1'b1;
    endtask

    task automatic test_out_of_range();
        ch_sel2 = 2'd1;
        repeat (4) tick();
        for (int k = 0; k < 8; k++) begin
            tick();
            total_cnt++;
            if (seg2 !== 7'h24) $display("FAIL ch1_of3: got %h want 24", seg2);
            else pass_cnt++;
        end
        ch_sel2 = 2'd3;
        repeat (4) tick();
        for (int k = 0; k < 8; k++) begin
            tick();
            total_cnt++;
            if (seg2 !== 7'h40) $display("FAIL ch_oor: got %h want 40", seg2);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_run();
        test_step();
        test_display();
        test_hold_then_step();
        test_mode_switch();
        test_reset_mid_scan();
        test_out_of_range();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
